// File: rtl/uart_rx_param_if.sv
// Receive-side handshake bundle for uart_rx_param.
// master = receiver (drives word/valid), slave = consumer (drives ready).
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with one-entry holding register.
// Define UART_RX_PARITY_EN to compile in the parity bit and parity_err.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic            CLOCK_50,
  input  logic            s_reset,
  input  logic            rx,
  uart_rx_param_if.master rxo,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun,
  output logic            busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PAR   = 3'd3;
`endif
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [1:0]           sync_q, sync_d;
  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 brk_q, brk_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;
  logic                 rxs, tick, stop_smp;

`ifdef UART_RX_PARITY_EN
  logic pbit_q, pbit_d;
  logic pe_q, pe_d;
  logic par_bad;

  assign par_bad = (^{shreg_q, pbit_q}) != 1'(PARITY_ODD);
`else
  logic unused_par;

  assign unused_par = 1'(PARITY_ODD);
`endif

  assign rxs  = sync_q[1];
  assign tick = (timer_q == '0);

  always_comb begin
    sync_d   = {sync_q[0], rx};
    state_d  = state_q;
    timer_d  = tick ? timer_q : timer_q - 1'b1;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    brk_d    = brk_q;
    data_d   = data_q;
    valid_d  = valid_q & ~rxo.rx_ready;
    fe_d     = 1'b0;
    ov_d     = 1'b0;
    stop_smp = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbit_d   = pbit_q;
    pe_d     = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        // after a break, re-arm only once the line has been high
        if (brk_q) begin
          if (rxs) brk_d = 1'b0;
        end else if (!rxs) begin
          state_d = S_START;
          timer_d = HALF;
        end
      end
      S_START: begin
        if (tick) begin
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            timer_d = FULL;
            idx_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shreg_d[idx_q] = rxs;
          timer_d        = FULL;
          idx_d          = idx_q + 1'b1;
          if (idx_q == LAST) begin
            idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PAR: begin
        if (tick) begin
          pbit_d  = rxs;
          timer_d = FULL;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          stop_smp = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (stop_smp) begin
      if (!rxs) begin
        fe_d  = 1'b1;
        brk_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        pe_d  = par_bad;
      end else if (par_bad) begin
        pe_d  = 1'b1;
`endif
      end else if (!valid_q || rxo.rx_ready) begin
        valid_d = 1'b1;
        data_d  = shreg_q;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (s_reset) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      brk_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbit_q  <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      brk_q   <= brk_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
`ifdef UART_RX_PARITY_EN
      pbit_q  <= pbit_d;
      pe_q    <= pe_d;
`endif
    end
  end

  assign rxo.rx_data  = data_q;
  assign rxo.rx_valid = valid_q;
  assign frame_err    = fe_q;
  assign overrun      = ov_q;
  assign busy         = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err   = pe_q;
`else
  assign parity_err   = 1'b0;
`endif

endmodule
